// File: rtl/conv3x3_stream_filter.sv
// 3x3 streaming image filter (bypass / Gaussian / sharpen) with its own line buffers.
// Latency: output k appears 3 cycles after input k+IMG_W+1 is accepted; the frame tail is self-flushed.
// Backpressure: none on the output; in_ready drops only for the IMG_W+1 tail-flush cycles.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   mode                 0/3 bypass, 1 Gaussian, 2 sharpen; latched on each accepted SOF pixel
//   in_valid/in_ready    input handshake; in_sof marks the first pixel of a frame
//   in_data              input pixel
//   out_valid/out_data   one output pixel per input pixel, raster order
//   out_sof/out_eof      first / last output pixel of a frame
//   frame_err            one-cycle pulse when an SOF arrives in the middle of a frame
module conv3x3_stream_filter #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eof,
    output logic              frame_err
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LW = $clog2(IMG_W + 2);
    localparam int SW = DATA_W + 4;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state;
    logic [CW-1:0]     in_col;
    logic [RW-1:0]     in_row;
    logic [LW-1:0]     fl_cnt;
    logic [LW-1:0]     lead;      // pushes seen this frame, saturating at IMG_W+1
    logic [RW-1:0]     o_row;
    logic [CW-1:0]     o_col;
    logic [1:0]        mode_q;

    logic              accept, start, abort, push, emit;
    logic [CW-1:0]     p_col;
    logic [DATA_W-1:0] p_dat;

    // Storage: two previous lines plus the 3x3 window (newest column is index 2).
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] w   [3][3];

    // Pipeline stage 1 (travels with the window register)
    logic              s1_vld, s1_sof, s1_eof, s1_brd;
    logic [1:0]        s1_mode;
    // Pipeline stage 2 (sums)
    logic              s2_vld, s2_sof, s2_eof;
    logic [1:0]        s2_sel;
    logic [DATA_W-1:0] s2_ctr;
    logic [SW-1:0]     s2_gsum, s2_ssum;

    logic [SW-1:0]     gsum, ssum, g_rnd;
    logic [DATA_W-1:0] res;

    assign accept = in_valid & in_ready;
    assign start  = accept & in_sof;
    assign abort  = start & (state == RUN);
    // A FLUSH cycle acts as a pseudo-accept so the last row drains out.
    assign push   = start | (accept & (state == RUN)) | (state == FLUSH);
    // The first IMG_W+1 pushes of a frame only fill the window.
    assign emit   = push & ~start & (lead == LW'(IMG_W + 1));
    assign p_col  = start ? '0 : in_col;
    assign p_dat  = (state == FLUSH) ? '0 : in_data;

    // Line buffers and window: contents need no reset, only the valids do.
    always_ff @(posedge clk) begin
        if (push) begin
            lb2[p_col] <= lb1[p_col];
            lb1[p_col] <= p_dat;
            for (int r = 0; r < 3; r++) begin
                w[r][0] <= w[r][1];
                w[r][1] <= w[r][2];
            end
            w[0][2] <= lb2[p_col];
            w[1][2] <= lb1[p_col];
            w[2][2] <= p_dat;
        end
    end

    function automatic logic [SW-1:0] ext(input logic [DATA_W-1:0] v);
        return {4'b0, v};
    endfunction

    // Window centre is w[1][1]; it is always the pixel being output, so border
    // pixels never need the (possibly wrapped) neighbours.
    always_comb begin
        gsum = ext(w[0][0]) + ext(w[0][2]) + ext(w[2][0]) + ext(w[2][2])
             + ((ext(w[0][1]) + ext(w[1][0]) + ext(w[1][2]) + ext(w[2][1])) << 1)
             + (ext(w[1][1]) << 2);
        // Two's complement in SW bits; range always fits.
        ssum = (ext(w[1][1]) << 2) + ext(w[1][1])
             - (ext(w[0][1]) + ext(w[1][0]) + ext(w[1][2]) + ext(w[2][1]));
    end

    always_comb begin
        g_rnd = s2_gsum + SW'(8);
        res   = s2_ctr;
        case (s2_sel)
            2'd1: res = DATA_W'(g_rnd >> 4);
            2'd2: begin
                if (s2_ssum[SW-1])
                    res = '0;
                else if (|s2_ssum[SW-2:DATA_W])
                    res = '1;
                else
                    res = s2_ssum[DATA_W-1:0];
            end
            default: res = s2_ctr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            in_col    <= '0;
            in_row    <= '0;
            fl_cnt    <= '0;
            lead      <= '0;
            o_row     <= '0;
            o_col     <= '0;
            mode_q    <= 2'd0;
            frame_err <= 1'b0;
            s1_vld    <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eof    <= 1'b0;
            s1_brd    <= 1'b0;
            s1_mode   <= 2'd0;
            s2_vld    <= 1'b0;
            s2_sof    <= 1'b0;
            s2_eof    <= 1'b0;
            s2_sel    <= 2'd0;
            s2_ctr    <= '0;
            s2_gsum   <= '0;
            s2_ssum   <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_data  <= '0;
        end else begin
            frame_err <= 1'b0;

            case (state)
                IDLE: ;
                RUN: begin
                    if (start) begin
                        frame_err <= 1'b1;
                    end else if (accept) begin
                        if (in_col == CW'(IMG_W - 1)) begin
                            in_col <= '0;
                            if (in_row == RW'(IMG_H - 1)) begin
                                state    <= FLUSH;
                                in_ready <= 1'b0;
                                fl_cnt   <= '0;
                            end else begin
                                in_row <= in_row + 1'b1;
                            end
                        end else begin
                            in_col <= in_col + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    in_col <= (in_col == CW'(IMG_W - 1)) ? '0 : in_col + 1'b1;
                    fl_cnt <= fl_cnt + 1'b1;
                    if (fl_cnt == LW'(IMG_W)) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // The SOF pixel is the frame's first push, so counting resumes at column 1.
            if (start) begin
                state  <= RUN;
                in_col <= CW'(1);
                in_row <= '0;
                mode_q <= mode;
            end

            if (start) begin
                lead  <= LW'(1);
                o_row <= '0;
                o_col <= '0;
            end else if (push) begin
                if (lead != LW'(IMG_W + 1))
                    lead <= lead + 1'b1;
                if (emit) begin
                    if (o_col == CW'(IMG_W - 1)) begin
                        o_col <= '0;
                        o_row <= o_row + 1'b1;
                    end else begin
                        o_col <= o_col + 1'b1;
                    end
                end
            end

            s1_vld  <= emit;
            s1_sof  <= emit & (o_row == '0) & (o_col == '0);
            s1_eof  <= emit & (o_row == RW'(IMG_H - 1)) & (o_col == CW'(IMG_W - 1));
            s1_brd  <= (o_row == '0) | (o_row == RW'(IMG_H - 1)) |
                       (o_col == '0) | (o_col == CW'(IMG_W - 1));
            s1_mode <= mode_q;

            // An in-frame SOF kills everything of the old frame still in flight.
            s2_vld  <= s1_vld & ~abort;
            s2_sof  <= s1_sof;
            s2_eof  <= s1_eof;
            s2_sel  <= (s1_brd || s1_mode == 2'd0 || s1_mode == 2'd3) ? 2'd0 : s1_mode;
            s2_ctr  <= w[1][1];
            s2_gsum <= gsum;
            s2_ssum <= ssum;

            out_valid <= s2_vld & ~abort;
            out_sof   <= s2_vld & ~abort & s2_sof;
            out_eof   <= s2_vld & ~abort & s2_eof;
            if (s2_vld)
                out_data <= res;
        end
    end
endmodule

// File: tb/tb_conv3x3_stream_filter.sv
module tb_conv3x3_stream_filter;
    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eof;
    logic       frame_err;

    conv3x3_stream_filter #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         k;
        logic [7:0] d;
        logic       sof;
        logic       eof;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail = 0;
    int         err_cyc = -1;
    logic [7:0] img     [N];
    logic [7:0] exp_img [N];

    // Output scoreboard and frame_err checker, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_valid) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got d=%0d sof=%0b eof=%0b at cyc %0d, required no output",
                         out_data, out_sof, out_eof, cyc);
            end else begin
                mon_e = q.pop_front();
                if (out_data !== mon_e.d || out_sof !== mon_e.sof || out_eof !== mon_e.eof || cyc != mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL out[%0d]: got d=%0d sof=%0b eof=%0b cyc=%0d, required d=%0d sof=%0b eof=%0b cyc=%0d",
                             mon_e.k, out_data, out_sof, out_eof, cyc, mon_e.d, mon_e.sof, mon_e.eof, mon_e.cyc);
                end
            end
        end
        if (frame_err || cyc == err_cyc) begin
            n_tests++;
            if (frame_err !== (cyc == err_cyc)) begin
                n_fail++;
                $display("FAIL frame_err: got %0b at cyc %0d, required %0b", frame_err, cyc, cyc == err_cyc);
            end
        end
    end

    function automatic logic [7:0] ref_px(input logic [1:0] m, input int r, input int c);
        int ctr, nb, dg, s;
        ctr = int'(img[r*W+c]);
        if (r == 0 || r == H-1 || c == 0 || c == W-1 || m == 2'd0 || m == 2'd3)
            return img[r*W+c];
        nb = int'(img[(r-1)*W+c]) + int'(img[(r+1)*W+c]) + int'(img[r*W+c-1]) + int'(img[r*W+c+1]);
        dg = int'(img[(r-1)*W+c-1]) + int'(img[(r-1)*W+c+1]) + int'(img[(r+1)*W+c-1]) + int'(img[(r+1)*W+c+1]);
        if (m == 2'd1) begin
            s = (dg + 2*nb + 4*ctr + 8) / 16;
            return 8'(s);
        end
        s = 5*ctr - nb;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

    task automatic make_exp(input logic [1:0] m);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_img[r*W+c] = ref_px(m, r, c);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < N; i++) begin
            img[i] = v;
            exp_img[i] = v;
        end
    endtask

    task automatic purge(input int t);
        while (q.size() > 0 && q[$].cyc > t) void'(q.pop_back());
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] d, input logic s, output int acc);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 100) begin
                $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, required <= %0d", guard, W + 1);
                n_fail++;
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $fatal(1, "in_ready timeout");
            end
        end
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Drives npix pixels of img[]; pushes expected outputs from exp_img[].
    task automatic run_frame(input logic [1:0] m, input int gapmax, input int npix,
                             input bit aborts, input bit chk_tail);
        int acc, lowc;
        for (int p = 0; p < npix; p++) begin
            if (gapmax > 0) idle($urandom_range(gapmax, 0));
            if (p == 0) mode = m;
            put(img[p], p == 0, acc);
            if (p == 0) begin
                // Mode changes mid-frame must be ignored until the next SOF.
                mode = (m == 2'd1) ? 2'd2 : 2'd1;
                if (aborts) begin
                    purge(acc);
                    err_cyc = acc + 1;
                end
            end
            if (p >= W + 1)
                q.push_back('{k: p-W-1, d: exp_img[p-W-1], sof: (p == W+1), eof: 1'b0, cyc: acc + 3});
        end
        if (npix == N) begin
            for (int j = 0; j <= W; j++)
                q.push_back('{k: N-W-1+j, d: exp_img[N-W-1+j], sof: 1'b0, eof: (j == W), cyc: acc + 4 + j});
            if (chk_tail) begin
                lowc = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (!in_ready) lowc++;
                    else break;
                end
                n_tests++;
                if (lowc != W + 1) begin
                    n_fail++;
                    $display("FAIL flush_ready_low: got %0d cycles, required %0d", lowc, W + 1);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: got %0d outputs still missing, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_tests++;
        if ({out_valid, out_sof, out_eof, frame_err, out_data, in_ready} !== {12'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL %s: got vld=%0b sof=%0b eof=%0b err=%0b data=%0d rdy=%0b, required 0 0 0 0 0 1",
                     name, out_valid, out_sof, out_eof, frame_err, out_data, in_ready);
        end
    endtask

    initial begin
        int acc;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_state");
        @(posedge clk);
        #1;

        // Pixels without SOF in IDLE are dropped.
        put(8'd55, 1'b0, acc);
        put(8'd66, 1'b0, acc);
        idle(2);

        // 1: flat field through Gaussian stays flat.
        fill(8'd100);
        run_frame(2'd1, 0, N, 1'b0, 1'b1);
        drain("flat");

        // 2: Gaussian impulse response of 160 at (2,3).
        fill(8'd0);
        img[2*W+3] = 8'd160;
        exp_img[2*W+3] = 8'd40;
        exp_img[1*W+3] = 8'd20;
        exp_img[3*W+3] = 8'd20;
        exp_img[2*W+2] = 8'd20;
        exp_img[2*W+4] = 8'd20;
        exp_img[1*W+2] = 8'd10;
        exp_img[1*W+4] = 8'd10;
        exp_img[3*W+2] = 8'd10;
        exp_img[3*W+4] = 8'd10;
        run_frame(2'd1, 0, N, 1'b0, 1'b1);
        drain("gauss_impulse");

        // 3: sharpen clamps high and low, then an in-range centre, then a border pixel.
        fill(8'd0);
        img[2*W+3] = 8'd100;
        exp_img[2*W+3] = 8'd255;
        run_frame(2'd2, 0, N, 1'b0, 1'b1);
        drain("sharp_clamp");
        fill(8'd0);
        img[2*W+3] = 8'd40;
        exp_img[2*W+3] = 8'd200;
        run_frame(2'd2, 0, N, 1'b0, 1'b1);
        drain("sharp_40");
        fill(8'd0);
        img[4] = 8'd200;
        exp_img[4] = 8'd200;
        run_frame(2'd2, 0, N, 1'b0, 1'b1);
        drain("sharp_border");

        // 4: non-linear ramp, gapless and with random input gaps; bypass on mode 3.
        for (int i = 0; i < N; i++) img[i] = 8'((i * 37 + i * i * 3) & 255);
        make_exp(2'd1);
        run_frame(2'd1, 0, N, 1'b0, 1'b1);
        drain("ramp_gapless");
        run_frame(2'd1, 3, N, 1'b0, 1'b1);
        drain("ramp_gaps");
        make_exp(2'd2);
        run_frame(2'd2, 2, N, 1'b0, 1'b1);
        drain("ramp_sharp_gaps");
        make_exp(2'd3);
        run_frame(2'd3, 1, N, 1'b0, 1'b1);
        drain("ramp_bypass");

        // 5: SOF re-asserted on pixel 20 aborts the frame; the next frame is intact.
        make_exp(2'd1);
        run_frame(2'd1, 0, 20, 1'b0, 1'b0);
        run_frame(2'd1, 0, N, 1'b1, 1'b1);
        drain("abort_restart");
        n_tests++;
        if (err_cyc < 0) begin
            n_fail++;
            $display("FAIL abort_seen: got err_cyc %0d, required >= 0", err_cyc);
        end

        // 6: reset pulse in the middle of the flush, then a clean frame.
        fill(8'd100);
        run_frame(2'd1, 0, N, 1'b0, 1'b0);
        idle(2);
        rst_n = 1'b0;
        purge(cyc);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_in_flush");
        @(posedge clk);
        #1;
        run_frame(2'd1, 0, N, 1'b0, 1'b1);
        drain("after_reset");

        idle(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
